// File: rtl/relu_stage_if.sv
// Chunk stream bundle for relu_stage: upstream chunk handshake, downstream
// chunk handshake with vector framing, and the busy status flag.
// master = the environment around the stage, slave = the stage itself.
interface relu_stage_if #(
  parameter int WorkingRegs = 8
);
  logic                        in_chunk_valid;
  logic [WorkingRegs-1:0][7:0] in_data;
  logic                        in_chunk_ready;
  logic [WorkingRegs-1:0][7:0] out_data;
  logic                        out_chunk_valid;
  logic                        out_chunk_ready;
  logic                        out_last;
  logic                        out_vector_valid;
  logic                        busy;

  modport master (
    output in_chunk_valid, in_data, out_chunk_ready,
    input  in_chunk_ready, out_data, out_chunk_valid, out_last,
           out_vector_valid, busy
  );

  modport slave (
    input  in_chunk_valid, in_data, out_chunk_ready,
    output in_chunk_ready, out_data, out_chunk_valid, out_last,
           out_vector_valid, busy
  );
endinterface

// File: rtl/relu_stage.sv
// relu_stage: per-lane int8 ReLU on a chunked vector stream.
// Each accepted chunk is activated on the way in and parked in a 2-entry
// FIFO together with a last-of-vector flag; the FIFO head drives the output.
// Optional feature: define RELU_LEAKY_EN to turn negative lanes into
// x >>> LeakShift (leaky ReLU) instead of 0.
// Lane i of in_data/out_data occupies bits [8*i+7 : 8*i].
module relu_stage #(
  parameter int InVecLength = 64,
  parameter int WorkingRegs = 8,
  parameter int LeakShift   = 3
) (
  input logic         clk_in,
  input logic         rst_in,
  relu_stage_if.slave bus
);
  localparam int ChunksPerVec = InVecLength / WorkingRegs;
  localparam int IdxW         = (ChunksPerVec > 1) ? $clog2(ChunksPerVec) : 1;
  localparam int DataW        = WorkingRegs * 8;
  localparam int EntryW       = DataW + 1;  // {last, data}
  localparam logic [IdxW-1:0] LastIdx = IdxW'(ChunksPerVec - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;

  // Reject configurations that cannot split a vector into whole chunks.
  generate
    if ((InVecLength % WorkingRegs) != 0 || LeakShift < 0) begin : g_cfg_err
      $error("relu_stage: InVecLength must be a multiple of WorkingRegs and LeakShift >= 0");
    end
  endgenerate

  // Per-lane activation of the incoming chunk.
  logic [WorkingRegs-1:0][7:0] act_data;

  generate
    for (genvar gi = 0; gi < WorkingRegs; gi++) begin : g_lane
      logic signed [7:0] x;
      assign x = bus.in_data[gi];
`ifdef RELU_LEAKY_EN
      // Arithmetic shift rounds toward -inf, so small negatives settle at -1.
      assign act_data[gi] = x[7] ? 8'(x >>> LeakShift) : x;
`else
      assign act_data[gi] = x[7] ? 8'd0 : x;
`endif
    end
  endgenerate

  logic [1:0]        count_q, count_d;
  logic              head_q, head_d;
  logic [IdxW-1:0]   in_idx_q, in_idx_d;
  logic [1:0]        state_q, state_d;
  logic [EntryW-1:0] mem_q [2];
  logic [EntryW-1:0] mem_d [2];

  logic              in_ready;
  logic              push;
  logic              pop;
  logic              in_last;
  logic              wr_ptr;
  logic [EntryW-1:0] head_entry;

  // Handshakes: ready depends only on registered occupancy (and reset).
  always_comb begin
    in_ready   = !rst_in && (count_q != 2'd2);
    push       = bus.in_chunk_valid && in_ready;
    pop        = (count_q != 2'd0) && bus.out_chunk_ready;
    in_last    = (in_idx_q == LastIdx);
    wr_ptr     = head_q ^ (count_q == 2'd1);
    head_entry = mem_q[head_q];
  end

  // Next-state for FIFO storage, pointers, chunk index and input FSM.
  always_comb begin
    mem_d    = mem_q;
    head_d   = head_q;
    count_d  = count_q;
    in_idx_d = in_idx_q;
    state_d  = state_q;

    if (push) begin
      mem_d[wr_ptr] = {in_last, act_data};
      in_idx_d      = in_last ? '0 : in_idx_q + IdxW'(1);
    end

    if (pop) begin
      head_d = ~head_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (push) state_d = in_last ? DRAIN : STREAM;
      end
      STREAM: begin
        if (push && in_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (push)                  state_d = in_last ? DRAIN : STREAM;
        else if (count_d == 2'd0)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: reset discards anything buffered or partially received.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_q  <= 2'd0;
      head_q   <= 1'b0;
      in_idx_q <= '0;
      state_q  <= IDLE;
    end else begin
      count_q  <= count_d;
      head_q   <= head_d;
      in_idx_q <= in_idx_d;
      state_q  <= state_d;
    end
  end

  // FIFO payload needs no reset; outputs are masked while the FIFO is empty.
  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

  // Output side driven purely from the head entry and registered state.
  always_comb begin
    bus.in_chunk_ready   = in_ready;
    bus.out_chunk_valid  = (count_q != 2'd0);
    bus.out_data         = (count_q != 2'd0) ? head_entry[DataW-1:0] : '0;
    bus.out_last         = (count_q != 2'd0) && head_entry[DataW];
    bus.out_vector_valid = pop && head_entry[DataW];
    bus.busy             = (state_q != IDLE) || (count_q != 2'd0);
  end
endmodule

// File: tb/tb_relu_stage.sv
// Scoreboard bench for relu_stage: every accepted chunk pushes its expected
// activated data and last flag; every cycle the FIFO head is compared with
// the queue front and handshake/status outputs with the occupancy model.
module tb_relu_stage;
  localparam int VL  = 64;
  localparam int WR  = 8;
  localparam int LS  = 3;
  localparam int CPV = VL / WR;
  localparam int DW  = WR * 8;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  relu_stage_if #(.WorkingRegs(WR)) bus ();

  relu_stage #(
    .InVecLength(VL),
    .WorkingRegs(WR),
    .LeakShift  (LS)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   idx_m  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference activation: floor division by 2**LS for leaky negatives.
  function automatic logic [7:0] act_ref(input logic signed [7:0] x);
    int v;
    int d;
    int m;
    v = x;
    if (v >= 0) return 8'(v);
`ifdef RELU_LEAKY_EN
    d = 1 << LS;
    m = ((v % d) + d) % d;
    return 8'((v - m) / d);
`else
    d = 0;
    m = 0;
    return 8'(d + m);
`endif
  endfunction

  function automatic logic [DW-1:0] relu_vec(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    for (int i = 0; i < WR; i++) r[i*8 +: 8] = act_ref(d[i*8 +: 8]);
    return r;
  endfunction

  function automatic logic [DW-1:0] pack8(input byte v [8]);
    logic [DW-1:0] r;
    for (int i = 0; i < WR; i++) r[i*8 +: 8] = v[i];
    return r;
  endfunction

  // One clock cycle: drive, check against the model, then update the model.
  task automatic step(input bit r, input bit iv, input logic [DW-1:0] d,
                      input bit ordy, output bit acc);
    bit exp_valid;
    bit exp_ready;
    bit exp_vv;
    @(negedge clk);
    rst                 = r;
    bus.in_chunk_valid  = iv;
    bus.in_data         = d;
    bus.out_chunk_ready = ordy;
    #1;
    exp_valid = (sb_q.size() != 0);
    exp_ready = !r && (sb_q.size() < 2);
    check_eq("in_chunk_ready", 64'(bus.in_chunk_ready), 64'(exp_ready));
    check_eq("out_chunk_valid", 64'(bus.out_chunk_valid), 64'(exp_valid));
    check_eq("busy", 64'(bus.busy), 64'((sb_q.size() != 0) || (idx_m != 0)));
    if (exp_valid) begin
      check_eq("out_data", 64'(bus.out_data), 64'(sb_q[0].data));
      check_eq("out_last", 64'(bus.out_last), 64'(sb_q[0].last));
      exp_vv = ordy && sb_q[0].last;
    end else begin
      check_eq("out_data_idle", 64'(bus.out_data), 64'(0));
      check_eq("out_last_idle", 64'(bus.out_last), 64'(0));
      exp_vv = 1'b0;
    end
    check_eq("out_vector_valid", 64'(bus.out_vector_valid), 64'(exp_vv));
    acc = iv && exp_ready;
    if (r) begin
      sb_q.delete();
      idx_m = 0;
    end else begin
      if (exp_valid && ordy) void'(sb_q.pop_front());
      if (acc) begin
        sb_q.push_back('{last: (idx_m == CPV - 1), data: relu_vec(d)});
        $display("accept chunk idx=%0d data=%h", idx_m, d);
        idx_m = (idx_m == CPV - 1) ? 0 : idx_m + 1;
      end
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input bit ordy);
    bit acc;
    int n;
    n = 0;
    do begin
      step(1'b0, 1'b1, d, ordy, acc);
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: chunk %h not accepted within %0d cycles", d, n);
    end
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      step(1'b0, 1'b0, '0, 1'b1, acc);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d chunks still expected", sb_q.size());
    end
    step(1'b0, 1'b0, '0, 1'b1, acc);
  endtask

  function automatic logic [DW-1:0] rnd_chunk();
    return {$urandom, $urandom};
  endfunction

  initial begin
    bit   acc;
    byte  v32 [8] = '{-5, 0, 3, 127, -128, 1, -1, 64};
    byte  v36 [8] = '{-8, -1, -128, 7, 0, 1, -2, 100};
    byte  vlim[8] = '{-128, 127, -127, 126, -9, -7, 8, -16};

    bus.in_chunk_valid  = 1'b0;
    bus.in_data         = '0;
    bus.out_chunk_ready = 1'b0;

    // Reset with a chunk offered: must be ignored, ready low.
    step(1'b1, 1'b1, rnd_chunk(), 1'b0, acc);
    step(1'b1, 1'b0, '0, 1'b0, acc);
    step(1'b0, 1'b0, '0, 1'b1, acc);

    // Single mixed-sign chunk, then finish that vector and drain.
    send(pack8(v32), 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, acc);
    for (int i = 0; i < CPV - 1; i++) send(rnd_chunk(), 1'b1);
    drain();

    // Full vector back to back.
    for (int i = 0; i < CPV; i++) send(rnd_chunk(), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1, acc);

    // Backpressure: third chunk refused while output is stalled.
    step(1'b0, 1'b1, pack8(vlim), 1'b0, acc);
    step(1'b0, 1'b1, rnd_chunk(), 1'b0, acc);
    begin
      logic [DW-1:0] c3;
      c3 = rnd_chunk();
      step(1'b0, 1'b1, c3, 1'b0, acc);
      step(1'b0, 1'b1, c3, 1'b0, acc);
      send(c3, 1'b1);
    end
    drain();

    // Reset mid-vector with two chunks buffered.
    step(1'b1, 1'b0, '0, 1'b1, acc);
    send(rnd_chunk(), 1'b1);
    send(rnd_chunk(), 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, acc);
    send(rnd_chunk(), 1'b0);
    send(rnd_chunk(), 1'b0);
    step(1'b1, 1'b1, rnd_chunk(), 1'b0, acc);
    step(1'b0, 1'b0, '0, 1'b0, acc);
    for (int i = 0; i < CPV; i++) send(rnd_chunk(), 1'b1);
    drain();

    // Leaky/plain negative handling on boundary values.
    send(pack8(v36), 1'b1);
    drain();

    // Random traffic with random backpressure.
    for (int i = 0; i < 80; i++)
      step(1'b0, 1'($urandom_range(0, 1)), rnd_chunk(), 1'($urandom_range(0, 3) != 0), acc);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/relu_stage.md
RELU_STAGE -- requirements
Module: relu_stage

Interface
REQ-001 SHALL have parameter InVecLength, default 64: elements per vector.
REQ-002 SHALL have parameter WorkingRegs, default 8: int8 lanes per chunk; InVecLength % WorkingRegs == 0 is required; ChunksPerVec = InVecLength/WorkingRegs.
REQ-003 SHALL have parameter LeakShift, default 3: negative-slope shift, used only under RELU_LEAKY_EN.
REQ-004 SHALL have port clk_in  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_in  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_chunk_valid  input  1  upstream chunk present.
REQ-007 SHALL have port in_data  input  WorkingRegs x 8 signed  upstream chunk; lane i is element i.
REQ-008 SHALL have port in_chunk_ready  output  1  stage accepts a chunk this cycle.
REQ-009 SHALL have port out_data  output  WorkingRegs x 8 signed  activated chunk; lane order preserved.
REQ-010 SHALL have port out_chunk_valid  output  1  out_data holds a valid chunk.
REQ-011 SHALL have port out_chunk_ready  input  1  downstream accepts out_data.
REQ-012 SHALL have port out_last  output  1  current out_data is the final chunk of a vector.
REQ-013 SHALL have port out_vector_valid  output  1  one-cycle pulse on the handshake of the final chunk.
REQ-014 SHALL have port busy  output  1  vector in flight or buffer non-empty.

Function
REQ-015 SHALL accept a chunk on in_chunk_valid && in_chunk_ready; SHALL emit one on out_chunk_valid && out_chunk_ready.
REQ-016 SHALL buffer chunks in a 2-entry FIFO, each entry holding activated data plus a last flag.
REQ-017 SHALL drive in_chunk_ready = (count < 2), from registered state only; no combinational path from out_chunk_ready.
REQ-018 SHALL drive out_chunk_valid = (count > 0), with out_data/out_last from the head entry.
REQ-019 SHALL have 1-cycle latency: a chunk accepted into an empty buffer in cycle N appears on out_data in cycle N+1.
REQ-020 SHALL apply per lane y = (x < 0) ? 0 : x; -128 -> 0, 127 -> 127; no widening, no overflow is possible.
REQ-021 SHALL count accepted chunks in in_idx 0..ChunksPerVec-1, wrapping to 0 after the last; an entry's last flag is (in_idx == ChunksPerVec-1).
REQ-022 SHALL, when ChunksPerVec == 1, set last on every chunk.
REQ-023 SHALL implement an input FSM: IDLE (in_idx==0, no partial vector) -> STREAM on accept of a non-last chunk; STREAM -> DRAIN on accept of the last chunk; DRAIN -> STREAM on accept of the next vector's first chunk (or stays DRAIN if that chunk is itself last); DRAIN -> IDLE when the buffer empties with no accept.
REQ-024 SHALL, on simultaneous push and pop with count==1, keep count at 1 and preserve order.
REQ-025 SHALL keep out_data, out_last and out_chunk_valid stable while out_chunk_valid && !out_chunk_ready.
REQ-026 SHALL drive busy = (state != IDLE) || (count != 0).

Reset
REQ-027 SHALL, on rst_in, clear count, in_idx and the FSM to IDLE, regardless of in-flight data; buffered chunks are discarded.
REQ-028 SHALL reset outputs: in_chunk_ready=0 during the reset cycle and 1 thereafter; out_chunk_valid=0, out_last=0, out_vector_valid=0, busy=0, out_data=0.
REQ-029 SHALL ignore in_chunk_valid in any cycle where rst_in is high.

Configuration
REQ-030 SHALL, with macro RELU_LEAKY_EN defined, output x >>> LeakShift (arithmetic, rounding toward negative infinity) for x < 0; LeakShift=3: -8 -> -1, -1 -> -1, -128 -> -16.
REQ-031 SHALL, without RELU_LEAKY_EN, output 0 for every x < 0 and ignore LeakShift.

Verification
REQ-032 SHALL cover: reset, then one chunk of [-5,0,3,127,-128,1,-1,64] (WorkingRegs=8, ChunksPerVec=8), out_chunk_ready=1 -> next cycle out_data=[0,0,3,127,0,1,0,64], out_last=0.
REQ-033 SHALL cover: 8 back-to-back chunks, out_chunk_ready=1 -> 8 outputs on consecutive cycles, out_last and out_vector_valid high only on the 8th handshake, busy low one cycle after.
REQ-034 SHALL cover: out_chunk_ready=0 with 3 chunks offered -> 2 accepted, in_chunk_ready=0, out_data frozen; release -> all 3 emitted in order.
REQ-035 SHALL cover: rst_in asserted after 4 of 8 chunks with 2 buffered -> next cycle out_chunk_valid=0, busy=0; following vector's first chunk reports in_idx from 0 (last only on its 8th chunk).
REQ-036 SHALL cover: RELU_LEAKY_EN, LeakShift=3, input [-8,-1,-128,7,...] -> [-1,-1,-16,7,...]; without macro -> [0,0,0,7,...].
